// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer controller: state encodings,
// the default counter width and the state-to-output decode.
package count_seq_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_CLEAR = 3'b001,
        ST_RUN   = 3'b010,
        ST_PAUSE = 3'b011,
        ST_DONE  = 3'b100
    } state_t;

    typedef struct packed {
        logic t;
        logic cnt_clr;
        logic busy;
        logic done;
    } outs_t;

    function automatic outs_t decode(input state_t s);
        outs_t o;
        o.t       = (s == ST_RUN);
        o.cnt_clr = (s == ST_CLEAR);
        o.busy    = (s == ST_CLEAR) || (s == ST_RUN) || (s == ST_PAUSE);
        o.done    = (s == ST_DONE);
        return o;
    endfunction

endpackage

// File: rtl/count_sequencer_ctrl.sv
// Sequencer for an external T-flip-flop counter: clears it, enables counting
// up to a latched limit, supports pause/stop/auto-reload and flags overruns.
module count_sequencer_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             reload_en,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q,
    output logic             t,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       state
);

    state_t           st;
    state_t           nxt;
    outs_t            outs_r;
    logic [WIDTH-1:0] lim_r;
    logic             load;
    logic             set_err;

    always_comb begin
        nxt     = st;
        load    = 1'b0;
        set_err = 1'b0;
        if (stop) begin
            nxt = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (start) begin
                        nxt  = ST_CLEAR;
                        load = 1'b1;
                    end
                end
                ST_CLEAR: nxt = (lim_r == '0) ? ST_DONE : ST_RUN;
                ST_RUN: begin
                    // t is registered, so stopping at lim_r-1 lets the last
                    // increment land on lim_r without overshooting it.
                    if (q >= lim_r) begin
                        nxt     = ST_DONE;
                        set_err = 1'b1;
                    end else if (q == lim_r - WIDTH'(1)) begin
                        nxt = ST_DONE;
                    end else if (pause) begin
                        nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: if (!pause) nxt = ST_RUN;
                ST_DONE:  nxt = reload_en ? ST_CLEAR : ST_IDLE;
                default:  nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: non-blocking assignments keep every register updating from the
    // same pre-edge values; outputs are loaded from decode(nxt) so they always
    // equal the decode of the state register without a combinational path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_IDLE;
            outs_r <= '0;
            lim_r  <= '0;
            err    <= 1'b0;
        end else begin
            st     <= nxt;
            outs_r <= decode(nxt);
            if (load) begin
                lim_r <= limit;
                err   <= 1'b0;
            end else if (set_err) begin
                err <= 1'b1;
            end
        end
    end

    assign t       = outs_r.t;
    assign cnt_clr = outs_r.cnt_clr;
    assign busy    = outs_r.busy;
    assign done    = outs_r.done;
    assign state   = st;

endmodule

// File: tb/tb_count_sequencer_ctrl.sv
// Scoreboard bench for count_sequencer_ctrl with a behavioural T-FF counter
// closing the q feedback loop.
module tb_count_sequencer_ctrl;

    localparam int W = 4;

    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_CLEAR = 3'b001;
    localparam logic [2:0] S_RUN   = 3'b010;
    localparam logic [2:0] S_PAUSE = 3'b011;
    localparam logic [2:0] S_DONE  = 3'b100;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, stop, pause, reload_en;
    logic [W-1:0] limit;
    logic [W-1:0] q, q_cnt, ovr_val;
    logic         ovr;
    logic         t, cnt_clr, busy, done, err;
    logic [2:0]   state;

    int n_checks = 0;
    int n_pass   = 0;
    int t_hi     = 0;
    int done_n   = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        bit         qv;
        logic [W-1:0] qe;
        logic       e;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // External counter: synchronous clear, toggle-enable increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       q_cnt <= '0;
        else if (cnt_clr) q_cnt <= '0;
        else if (t)       q_cnt <= q_cnt + W'(1);
    end

    assign q = ovr ? ovr_val : q_cnt;

    count_sequencer_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .reload_en(reload_en), .limit(limit), .q(q), .t(t), .cnt_clr(cnt_clr),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic push(input string tag, input logic [2:0] st, input bit qv,
                        input logic [W-1:0] qe, input logic e);
        exp_t x;
        x.tag = tag; x.st = st; x.qv = qv; x.qe = qe; x.e = e;
        sb.push_back(x);
    endtask

    function automatic logic [3:0] exp_outs(input logic [2:0] s);
        return {s == S_RUN, s == S_CLEAR,
                s == S_CLEAR || s == S_RUN || s == S_PAUSE, s == S_DONE};
    endfunction

    task automatic step();
        exp_t x;
        @(negedge clk);
        if (t)    t_hi++;
        if (done) done_n++;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            check({x.tag, ".state"}, state, x.st);
            check({x.tag, ".outs"}, {t, cnt_clr, busy, done}, exp_outs(x.st));
            check({x.tag, ".err"}, err, x.e);
            if (x.qv) check({x.tag, ".q"}, q, x.qe);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        start = 0; stop = 0; pause = 0; reload_en = 0; limit = '0;
        ovr = 0; ovr_val = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst.state", state, S_IDLE);
        check("rst.outs", {t, cnt_clr, busy, done, err}, 5'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // limit=5: one CLEAR, five RUN cycles, DONE with q=5, back to IDLE
        t_hi = 0; done_n = 0;
        push("l5.clr", S_CLEAR, 0, 0, 0);
        for (int i = 0; i < 5; i++) push("l5.run", S_RUN, 1, W'(i), 0);
        push("l5.done", S_DONE, 1, 5, 0);
        push("l5.idle", S_IDLE, 1, 5, 0);
        limit = 5; start = 1;
        step(); start = 0;
        steps(7);
        check("l5.t_cycles", t_hi, 5);
        check("l5.done_pulses", done_n, 1);

        // limit=0: CLEAR straight to DONE, counter never enabled
        t_hi = 0; done_n = 0;
        push("l0.clr", S_CLEAR, 0, 0, 0);
        push("l0.done", S_DONE, 1, 0, 0);
        push("l0.idle", S_IDLE, 1, 0, 0);
        limit = 0; start = 1;
        step(); start = 0;
        steps(2);
        check("l0.t_cycles", t_hi, 0);
        check("l0.done_pulses", done_n, 1);

        // limit=8 with a 3-cycle pause holding q at 3
        t_hi = 0; done_n = 0;
        push("p8.clr", S_CLEAR, 0, 0, 0);
        for (int i = 0; i < 3; i++) push("p8.run", S_RUN, 1, W'(i), 0);
        for (int i = 0; i < 3; i++) push("p8.pause", S_PAUSE, 1, 3, 0);
        for (int i = 3; i < 8; i++) push("p8.run", S_RUN, 1, W'(i), 0);
        push("p8.done", S_DONE, 1, 8, 0);
        push("p8.idle", S_IDLE, 1, 8, 0);
        limit = 8; start = 1;
        step(); start = 0;
        steps(3);
        pause = 1;
        steps(3);
        pause = 0;
        steps(7);
        check("p8.t_cycles", t_hi, 8);
        check("p8.done_pulses", done_n, 1);

        // limit=10 aborted by stop as q reaches 4; start+stop in IDLE ignored
        t_hi = 0; done_n = 0;
        push("s10.clr", S_CLEAR, 0, 0, 0);
        for (int i = 0; i < 4; i++) push("s10.run", S_RUN, 1, W'(i), 0);
        for (int i = 0; i < 3; i++) push("s10.idle", S_IDLE, 1, 4, 0);
        limit = 10; start = 1;
        step(); start = 0;
        steps(4);
        stop = 1;
        step();
        start = 1;
        step();
        start = 0; stop = 0;
        step();
        check("s10.done_pulses", done_n, 0);

        // auto-reload with limit=3; limit change mid-run must not matter
        t_hi = 0; done_n = 0;
        push("r3.clr", S_CLEAR, 0, 0, 0);
        for (int i = 0; i < 3; i++) push("r3.run", S_RUN, 1, W'(i), 0);
        push("r3.done", S_DONE, 1, 3, 0);
        push("r3.clr2", S_CLEAR, 1, 3, 0);
        for (int i = 0; i < 3; i++) push("r3.run2", S_RUN, 1, W'(i), 0);
        push("r3.done2", S_DONE, 1, 3, 0);
        push("r3.idle", S_IDLE, 1, 3, 0);
        limit = 3; reload_en = 1; start = 1;
        step(); start = 0;
        step(); limit = 9;
        steps(8);
        reload_en = 0;
        step();
        check("r3.t_cycles", t_hi, 6);
        check("r3.done_pulses", done_n, 2);

        // overrun: q forced to 12 while lim_r=6; err sticky until next start
        t_hi = 0; done_n = 0;
        push("ov.clr", S_CLEAR, 0, 0, 0);
        push("ov.run", S_RUN, 1, 0, 0);
        push("ov.done", S_DONE, 0, 0, 1);
        push("ov.idle", S_IDLE, 1, 1, 1);
        push("ov.clr2", S_CLEAR, 0, 0, 0);
        push("ov.run2", S_RUN, 1, 0, 0);
        push("ov.run2", S_RUN, 1, 1, 0);
        push("ov.done2", S_DONE, 1, 2, 0);
        push("ov.idle2", S_IDLE, 1, 2, 0);
        limit = 6; start = 1;
        step(); start = 0;
        step();
        ovr_val = 12; ovr = 1;
        step();
        ovr = 0;
        step();
        limit = 2; start = 1;
        step(); start = 0;
        steps(4);
        check("ov.done_pulses", done_n, 2);

        // reset asserted mid-run clears everything immediately
        t_hi = 0; done_n = 0;
        push("rr.clr", S_CLEAR, 0, 0, 0);
        push("rr.run", S_RUN, 1, 0, 0);
        push("rr.run", S_RUN, 1, 1, 0);
        limit = 10; start = 1;
        step(); start = 0;
        steps(2);
        #2 rst_n = 1'b0;
        #1;
        check("rr.state", state, S_IDLE);
        check("rr.outs", {t, cnt_clr, busy, done, err}, 5'b0);
        @(negedge clk);
        rst_n = 1'b1;
        push("rr.idle", S_IDLE, 1, 0, 0);
        push("rr.idle", S_IDLE, 1, 0, 0);
        steps(2);
        check("rr.done_pulses", done_n, 0);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/count_sequencer_ctrl.md
COUNT_SEQUENCER_CTRL -- requirements
Module: count_sequencer_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begin a count run; sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: abort any run and return to IDLE.
REQ-006 The block SHALL have port pause, input, 1 bit: hold the counter while asserted during a run.
REQ-007 The block SHALL have port reload_en, input, 1 bit: restart automatically after DONE.
REQ-008 The block SHALL have port limit, input, WIDTH bits: terminal count, latched at start.
REQ-009 The block SHALL have port q, input, WIDTH bits: counter value fed back from the T-flip-flop counter.
REQ-010 The block SHALL have port t, output, 1 bit: count enable (toggle input) to the counter.
REQ-011 The block SHALL have port cnt_clr, output, 1 bit: active-high clear request to the counter.
REQ-012 The block SHALL have port busy, output, 1 bit: high in CLEAR, RUN and PAUSE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at run completion.
REQ-014 The block SHALL have port err, output, 1 bit: sticky flag for counter overrun.
REQ-015 The block SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-016 The FSM SHALL have states IDLE=000, CLEAR=001, RUN=010, PAUSE=011 and DONE=100, held in a state register.
REQ-017 Outputs SHALL decode from the state register only: t=1 in RUN, cnt_clr=1 in CLEAR, busy=1 in CLEAR/RUN/PAUSE, done=1 in DONE.
REQ-018 In IDLE with start=1 and stop=0, the block SHALL latch limit into lim_r, clear err and enter CLEAR.
REQ-019 From CLEAR, the block SHALL enter DONE if lim_r==0 and otherwise enter RUN, so cnt_clr is exactly one cycle wide.
REQ-020 In RUN with q==lim_r-1, the block SHALL enter DONE on that edge, so the counter ends at exactly lim_r with no extra increment.
REQ-021 In RUN with q>=lim_r (overrun), the block SHALL set err and enter DONE.
REQ-022 In RUN with pause=1 and no terminal condition, the block SHALL enter PAUSE; in PAUSE with pause=0, it SHALL return to RUN.
REQ-023 Terminal detection SHALL take priority over pause on the same edge.
REQ-024 stop=1 SHALL force IDLE from any state on the next edge, without a done pulse; stop SHALL win over start, terminal and pause.
REQ-025 From DONE, the block SHALL enter CLEAR if reload_en=1 (reusing lim_r) and otherwise enter IDLE.
REQ-026 start outside IDLE and changes to limit after latching SHALL be ignored.
REQ-027 q SHALL be stable (ripple settled) before each rising clk edge; the block SHALL sample q synchronously and SHALL NOT resynchronise it.

Reset
REQ-028 On rst_n=0, the block SHALL immediately set state=IDLE, t=0, cnt_clr=0, busy=0, done=0, err=0 and lim_r=0.
REQ-029 Reset asserted mid-run SHALL abort the run with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-030 Package count_seq_pkg SHALL hold the state encodings and the WIDTH default.
REQ-031 The block SHALL be a single module with no sub-module; the counter SHALL be instantiated externally beside it.

Verification
REQ-032 The bench SHALL cover: limit=5, start pulse -> cnt_clr for 1 cycle, t high for exactly 5 cycles, q ends at 5, done pulses once, busy falls.
REQ-033 The bench SHALL cover: limit=0 -> CLEAR then DONE, t never asserted, done pulses once.
REQ-034 The bench SHALL cover: limit=8, pause asserted for 3 cycles at q=3 -> t low for 3 cycles, q holds 3, total t-high cycles still 8.
REQ-035 The bench SHALL cover: limit=10, stop at q=4 -> IDLE next edge, no done pulse, q holds 4; start and stop together in IDLE -> stays IDLE.
REQ-036 The bench SHALL cover: reload_en=1, limit=3 -> repeating sequence CLEAR, RUN x3, DONE with done every 5 cycles; limit changed mid-run is ignored.
REQ-037 The bench SHALL cover: forced q=12 with lim_r=6 in RUN -> err=1 and DONE; rst_n low mid-RUN -> immediate IDLE with all outputs 0.
